// File: rtl/ldpc_enc_ctrl_pkg.sv
// Shared definitions for the LDPC encoder frame sequencer: state codes,
// a ceiling-log2 helper and the default counter widths.
package ldpc_enc_ctrl_pkg;

    // Frame sequencer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_PAR  = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    typedef logic [1:0] state_t;

    // Bits needed to hold 0..n-1 (never less than one bit)
    function automatic int clogb2(input int n);
        int r;
        r = 32'sd1;
        for (int i = 32'sd1; i < 32'sd31; i++) begin
            if ((32'sd1 << i) < n) begin
                r = i + 32'sd1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    localparam int DATA_NUM_DEF = 32'sd36;
    localparam int PAR_NUM_DEF  = 32'sd36;
    localparam int DCNT_W_DEF   = clogb2(DATA_NUM_DEF);
    localparam int PCNT_W_DEF   = clogb2(PAR_NUM_DEF);

endpackage

// File: rtl/ldpc_enc_frame_cnt.sv
// Generic frame counter: synchronous load, increment enable and a
// terminal-count flag. Frozen while i_clkena is low.
module ldpc_enc_frame_cnt #(
    parameter int pW  = 6,
    parameter int pTC = 35
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clkena,
    input  logic          i_load,
    input  logic [pW-1:0] i_load_val,
    input  logic          i_inc,
    output logic          o_tc
);
    localparam logic [pW-1:0] TC_V = pW'(pTC);
    localparam logic [pW-1:0] ONE  = pW'(1);

    logic [pW-1:0] r_cnt;

    // Load takes priority over increment; hold otherwise
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= {pW{1'b0}};
        end else if (i_clkena) begin
            if (i_load) begin
                r_cnt <= i_load_val;
            end else if (i_inc) begin
                r_cnt <= r_cnt + ONE;
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    assign o_tc = (r_cnt == TC_V);

endmodule

// File: rtl/ldpc_enc_frame_ctrl.sv
// Frame sequencer in front of the on-fly LDPC encoder. Forwards pDATA_NUM
// payload words, then generates pPAR_NUM filler-valid cycles for parity,
// with sop/eop/eof strobes. Everything advances only on iclkena & ienc_rdy.
// Optional macro LDPC_ENC_CTRL_B2B_EN: skip the idle cycle after eof so the
// next frame's sop can follow eof immediately.
module ldpc_enc_frame_ctrl #(
    parameter int pDAT_W    = 8,
    parameter int pTAG_W    = 4,
    parameter int pDATA_NUM = 36,
    parameter int pPAR_NUM  = 36
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              iclkena,
    input  logic              isop,
    input  logic              ival,
    input  logic [pTAG_W-1:0] itag,
    input  logic [pDAT_W-1:0] idat,
    output logic              ordy,
    input  logic              ienc_rdy,
    output logic              oenc_sop,
    output logic              oenc_eop,
    output logic              oenc_eof,
    output logic              oenc_val,
    output logic [pTAG_W-1:0] oenc_tag,
    output logic [pDAT_W-1:0] oenc_dat,
    output logic              obusy,
    output logic              oerr
);
    import ldpc_enc_ctrl_pkg::*;

    localparam int DCNT_W = clogb2(pDATA_NUM);
    localparam int PCNT_W = clogb2(pPAR_NUM);
    // The sop word is already the first payload word, so dcnt starts at 1
    localparam logic [DCNT_W-1:0] DCNT_START = DCNT_W'(1);
    localparam logic [PCNT_W-1:0] PCNT_START = {PCNT_W{1'b0}};

    state_t              r_state;
    logic                r_val, r_sop, r_eop, r_eof, r_busy, r_err;
    logic [pTAG_W-1:0]   r_tag;
    logic [pDAT_W-1:0]   r_dat;

    state_t              w_state_nxt;
    logic                w_val_nxt, w_sop_nxt, w_eop_nxt, w_eof_nxt, w_err;
    logic [pTAG_W-1:0]   w_tag_nxt;
    logic [pDAT_W-1:0]   w_dat_nxt;
    logic                w_adv, w_rdy, w_acc;
    logic                w_dload, w_dinc, w_dtc;
    logic                w_pload, w_pinc, w_ptc;

    assign w_adv = iclkena & ienc_rdy;
    // Ready is held low while reset is active so nothing is accepted then
    assign w_rdy = ireset & w_adv & ((r_state == ST_IDLE) | (r_state == ST_DATA));
    assign w_acc = ival & w_rdy;

    // Next-state, next-output and counter control decode
    always_comb begin
        w_state_nxt = r_state;
        w_val_nxt   = 1'b0;
        w_sop_nxt   = 1'b0;
        w_eop_nxt   = 1'b0;
        w_eof_nxt   = 1'b0;
        w_tag_nxt   = r_tag;
        w_dat_nxt   = {pDAT_W{1'b0}};
        w_err       = 1'b0;
        w_dload     = 1'b0;
        w_dinc      = 1'b0;
        w_pload     = 1'b0;
        w_pinc      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    if (isop) begin
                        w_sop_nxt   = 1'b1;
                        w_val_nxt   = 1'b1;
                        w_dat_nxt   = idat;
                        w_tag_nxt   = itag;
                        w_dload     = 1'b1;
                        w_state_nxt = ST_DATA;
                    end else begin
                        w_err = 1'b1;
                    end
                end else begin
                    w_err = 1'b0;
                end
            end
            ST_DATA: begin
                if (w_acc) begin
                    if (isop) begin
                        w_err = 1'b1;
                    end else begin
                        w_val_nxt = 1'b1;
                        w_dat_nxt = idat;
                        if (w_dtc) begin
                            w_eop_nxt   = 1'b1;
                            w_pload     = 1'b1;
                            w_state_nxt = ST_PAR;
                        end else begin
                            w_dinc = 1'b1;
                        end
                    end
                end else begin
                    w_val_nxt = 1'b0;
                end
            end
            ST_PAR: begin
                if (w_adv) begin
                    w_val_nxt = 1'b1;
                    if (w_ptc) begin
                        w_eof_nxt = 1'b1;
`ifdef LDPC_ENC_CTRL_B2B_EN
                        w_state_nxt = ST_IDLE;
`else
                        w_state_nxt = ST_GAP;
`endif
                    end else begin
                        w_pinc = 1'b1;
                    end
                end else begin
                    w_val_nxt = 1'b0;
                end
            end
            ST_GAP: begin
                if (w_adv) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_GAP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Payload word counter
    ldpc_enc_frame_cnt #(.pW(DCNT_W), .pTC(pDATA_NUM - 1)) u_dcnt (
        .i_clk      (iclk),
        .i_rst_n    (ireset),
        .i_clkena   (iclkena),
        .i_load     (w_dload),
        .i_load_val (DCNT_START),
        .i_inc      (w_dinc),
        .o_tc       (w_dtc)
    );

    // Parity cycle counter
    ldpc_enc_frame_cnt #(.pW(PCNT_W), .pTC(pPAR_NUM - 1)) u_pcnt (
        .i_clk      (iclk),
        .i_rst_n    (ireset),
        .i_clkena   (iclkena),
        .i_load     (w_pload),
        .i_load_val (PCNT_START),
        .i_inc      (w_pinc),
        .o_tc       (w_ptc)
    );

    // State and encoder-side outputs, frozen whenever the encoder stalls
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            r_state <= ST_IDLE;
            r_val   <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_eof   <= 1'b0;
            r_tag   <= {pTAG_W{1'b0}};
            r_dat   <= {pDAT_W{1'b0}};
            r_busy  <= 1'b0;
        end else if (w_adv) begin
            r_state <= w_state_nxt;
            r_val   <= w_val_nxt;
            r_sop   <= w_sop_nxt;
            r_eop   <= w_eop_nxt;
            r_eof   <= w_eof_nxt;
            r_tag   <= w_tag_nxt;
            r_dat   <= w_dat_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Protocol error pulse; cleared on any enabled cycle without an error
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            r_err <= 1'b0;
        end else if (iclkena) begin
            r_err <= w_err;
        end
    end

    assign ordy     = w_rdy;
    assign oenc_val = r_val;
    assign oenc_sop = r_sop;
    assign oenc_eop = r_eop;
    assign oenc_eof = r_eof;
    assign oenc_tag = r_tag;
    assign oenc_dat = r_dat;
    assign obusy    = r_busy;
    assign oerr     = r_err;

endmodule

// File: tb/tb_ldpc_enc_frame_ctrl.sv
// Self-checking bench for ldpc_enc_frame_ctrl: directed frames plus a
// randomized phase, all compared every cycle against a count-based model.
module tb_ldpc_enc_frame_ctrl;
    localparam int DW = 8;
    localparam int TW = 4;
    localparam int DN = 36;
    localparam int PN = 36;
`ifdef LDPC_ENC_CTRL_B2B_EN
    localparam bit B2B     = 1'b1;
    localparam int EXP_GAP = 0;
`else
    localparam bit B2B     = 1'b0;
    localparam int EXP_GAP = 1;
`endif

    logic iclk = 1'b0, ireset = 1'b1, iclkena = 1'b1, isop = 1'b0, ival = 1'b0, ienc_rdy = 1'b1;
    logic [TW-1:0] itag = '0;
    logic [DW-1:0] idat = '0;
    logic ordy, oenc_sop, oenc_eop, oenc_eof, oenc_val, obusy, oerr;
    logic [TW-1:0] oenc_tag;
    logic [DW-1:0] oenc_dat;

    ldpc_enc_frame_ctrl #(.pDAT_W(DW), .pTAG_W(TW), .pDATA_NUM(DN), .pPAR_NUM(PN)) dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .isop(isop), .ival(ival),
        .itag(itag), .idat(idat), .ordy(ordy), .ienc_rdy(ienc_rdy),
        .oenc_sop(oenc_sop), .oenc_eop(oenc_eop), .oenc_eof(oenc_eof), .oenc_val(oenc_val),
        .oenc_tag(oenc_tag), .oenc_dat(oenc_dat), .obusy(obusy), .oerr(oerr)
    );

    always #5 iclk = ~iclk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Encoder ready / clock enable driver: steady, random, or forced low
    int rdy_mode  = 0;
    int force_low = 0;
    always @(negedge iclk) begin
        #1;
        if (force_low > 0) begin
            ienc_rdy = 1'b0;
            iclkena  = 1'b1;
            force_low--;
        end else if (rdy_mode != 0) begin
            ienc_rdy = ($urandom_range(0, 4) != 0);
            iclkena  = ($urandom_range(0, 9) != 0);
        end else begin
            ienc_rdy = 1'b1;
            iclkena  = 1'b1;
        end
    end

    // Behavioural model: frame progress kept as plain counts
    int m_words = 0;   // payload words taken in the current frame (DN => parity phase)
    int m_par   = 0;   // parity valids emitted so far
    bit m_gap   = 1'b0;
    logic [TW-1:0] m_tag = '0;
    logic e_val = 1'b0, e_sop = 1'b0, e_eop = 1'b0, e_eof = 1'b0, e_busy = 1'b0, e_err = 1'b0;
    logic [TW-1:0] e_tag = '0;
    logic [DW-1:0] e_dat = '0;

    // Observed frame statistics (from DUT outputs) for literal checks
    int obs_idx = 0, obs_sop_pos = 0, obs_eop_pos = 0, obs_eof_pos = 0;
    int frames_obs = 0, err_obs = 0, cyc = 0, eof_cyc = 0, last_gap = -1;
    logic [TW-1:0] obs_tags[$];

    logic s_rst, s_en, s_rdy, s_val, s_sop, s_adv, x_ordy, acc;
    logic [TW-1:0] s_tag;
    logic [DW-1:0] s_dat;

    // Compare process: sample inputs just before the edge, check outputs just after
    always begin
        @(negedge iclk);
        #4;
        s_rst = ireset; s_en = iclkena; s_rdy = ienc_rdy; s_val = ival;
        s_sop = isop; s_tag = itag; s_dat = idat;
        s_adv  = s_en & s_rdy;
        x_ordy = s_rst & s_adv & !m_gap & (m_words < DN);
        chk("ordy", 32'(ordy), 32'(x_ordy));
        acc = s_val & x_ordy;
        @(posedge iclk);
        #1;
        cyc++;
        if (!s_rst) begin
            m_words = 0; m_par = 0; m_gap = 1'b0; m_tag = '0;
            e_val = 0; e_sop = 0; e_eop = 0; e_eof = 0; e_busy = 0; e_err = 0;
            e_tag = '0; e_dat = '0;
        end else begin
            if (s_en) e_err = 1'b0;
            if (s_adv) begin
                e_val = 0; e_sop = 0; e_eop = 0; e_eof = 0; e_dat = '0;
                if (m_gap) begin
                    m_gap = 1'b0;
                end else if (m_words == DN) begin
                    e_val = 1'b1;
                    m_par++;
                    if (m_par == PN) begin
                        e_eof = 1'b1; m_words = 0; m_par = 0; m_gap = (B2B == 1'b0);
                    end
                end else if (acc) begin
                    if (m_words == 0) begin
                        if (s_sop) begin
                            m_tag = s_tag; e_sop = 1'b1; e_val = 1'b1; e_dat = s_dat; m_words = 1;
                        end else begin
                            e_err = 1'b1;
                        end
                    end else if (s_sop) begin
                        e_err = 1'b1;
                    end else begin
                        e_val = 1'b1; e_dat = s_dat; m_words++;
                        if (m_words == DN) e_eop = 1'b1;
                    end
                end
                e_tag  = m_tag;
                e_busy = (m_words != 0) || m_gap;
            end
        end
        chk("strobes", 32'({oenc_val, oenc_sop, oenc_eop, oenc_eof}), 32'({e_val, e_sop, e_eop, e_eof}));
        chk("tag", 32'(oenc_tag), 32'(e_tag));
        chk("dat", 32'(oenc_dat), 32'(e_dat));
        chk("busy", 32'(obusy), 32'(e_busy));
        chk("err", 32'(oerr), 32'(e_err));
        if (!s_rst) begin
            obs_idx = 0;
        end else begin
            if (s_en && oerr) err_obs++;
            if (s_adv && oenc_val) begin
                obs_idx++;
                if (oenc_sop) begin obs_sop_pos = obs_idx; last_gap = cyc - eof_cyc - 1; end
                if (oenc_eop) obs_eop_pos = obs_idx;
                if (oenc_eof) begin
                    obs_eof_pos = obs_idx; obs_idx = 0; frames_obs++;
                    obs_tags.push_back(oenc_tag); eof_cyc = cyc;
                end
            end
        end
    end

    // Present one word and wait (bounded) until it is taken; call at a negedge
    task automatic send_word(input bit sop, input logic [TW-1:0] tag, input logic [DW-1:0] dat);
        int n = 0;
        bit done = 1'b0;
        ival = 1'b1; isop = sop; itag = tag; idat = dat;
        while (!done) begin
            #4;
            done = (ordy === 1'b1);
            @(negedge iclk);
            n++;
            if (!done && n > 400) begin
                total++; bad++;
                $display("FAIL send_word: no ready after %0d cycles", n);
                done = 1'b1;
            end
        end
        ival = 1'b0; isop = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge iclk);
    endtask

    task automatic send_frame(input logic [TW-1:0] tag, input bit bubble, input int err_at, input bit drop_after);
        for (int w = 0; w < DN; w++) begin
            if (bubble && (w % 3 == 2)) idle(1);
            if (w == err_at) send_word(1'b1, tag, 8'hEE);
            send_word(w == 0, tag, 8'($urandom));
            if (w == DN - 1 && drop_after) force_low = 1;
        end
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames_obs < target && n < 2000) begin
            @(negedge iclk);
            n++;
        end
        if (frames_obs < target) begin
            total++; bad++;
            $display("FAIL wait_frames: got %0d frames expected %0d", frames_obs, target);
        end
    endtask

    task automatic frame_literals(input string nm, input logic [TW-1:0] tag);
        chk({nm, "_sop_pos"}, 32'(obs_sop_pos), 32'd1);
        chk({nm, "_eop_pos"}, 32'(obs_eop_pos), 32'd36);
        chk({nm, "_eof_pos"}, 32'(obs_eof_pos), 32'd72);
        chk({nm, "_tag"}, 32'(obs_tags[frames_obs-1]), 32'(tag));
    endtask

    initial begin
        int e0, n0, n;
        #1 ireset = 1'b0;
        idle(2);
        chk("rst_outs", 32'({oenc_val, oenc_sop, oenc_eop, oenc_eof, obusy, oerr, oenc_tag, oenc_dat}), 32'd0);
        ireset = 1'b1;
        idle(1);

        // Plain frame
        send_frame(4'h9, 1'b0, -1, 1'b0);
        wait_frames(1);
        idle(3);
        frame_literals("f1", 4'h9);
        chk("f1_err", 32'(err_obs), 32'd0);

        // One-cycle encoder stall right after eop
        send_frame(4'hA, 1'b0, -1, 1'b1);
        wait_frames(2);
        idle(3);
        frame_literals("f2", 4'hA);

        // Upstream bubbles every third word
        send_frame(4'hC, 1'b1, -1, 1'b0);
        wait_frames(3);
        idle(3);
        frame_literals("f3", 4'hC);

        // Stray word in idle and an extra isop at word 10
        e0 = err_obs;
        send_word(1'b0, 4'h2, 8'h55);
        idle(2);
        send_frame(4'h6, 1'b0, 10, 1'b0);
        wait_frames(4);
        idle(3);
        frame_literals("f4", 4'h6);
        chk("f4_errs", 32'(err_obs - e0), 32'd2);

        // Back-to-back frames
        n0 = frames_obs;
        send_frame(4'h3, 1'b0, -1, 1'b0);
        send_frame(4'h5, 1'b0, -1, 1'b0);
        wait_frames(n0 + 2);
        idle(3);
        chk("b2b_gap", 32'(last_gap), 32'(EXP_GAP));
        chk("b2b_tag1", 32'(obs_tags[n0]), 32'd3);
        frame_literals("b2b2", 4'h5);

        // Reset at parity word 20
        n0 = frames_obs;
        send_frame(4'h7, 1'b0, -1, 1'b0);
        n = 0;
        while (obs_idx < DN + 20 && n < 500) begin @(negedge iclk); n++; end
        chk("rst_reach_par20", 32'(obs_idx), 32'(DN + 20));
        ireset = 1'b0;
        idle(2);
        chk("rst_mid_outs", 32'({oenc_val, oenc_sop, oenc_eop, oenc_eof, obusy, oerr, oenc_tag, oenc_dat}), 32'd0);
        ireset = 1'b1;
        idle(1);
        send_frame(4'h8, 1'b0, -1, 1'b0);
        wait_frames(n0 + 1);
        idle(3);
        chk("rst_no_eof", 32'(frames_obs), 32'(n0 + 1));
        frame_literals("post_rst", 4'h8);

        // Randomized phase: random stalls, clock-enable gaps, bubbles and errors
        rdy_mode = 1;
        n0 = frames_obs;
        for (int f = 0; f < 6; f++) begin
            if ($urandom_range(0, 2) == 0) send_word(1'b0, 4'(f), 8'($urandom));
            send_frame(4'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DN - 1)) : -1, 1'b0);
            if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(0, 5)));
        end
        wait_frames(n0 + 6);
        rdy_mode = 0;
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
